// File: rtl/l1_trigger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l1_trigger_pkg
//  Purpose  : Shared types and constants for the L1 trigger arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package l1_trigger_pkg;

    // Default geometry; the event record type is built from these.
    localparam int DEF_NBEAMS    = 2;
    localparam int DEF_TIME_BITS = 32;

    // Width of the saturating dropped-record counter.
    localparam int OVF_BITS      = 16;

    // One coalesced event: timestamp in the MSBs, beam bitmap in the LSBs.
    typedef struct packed {
        logic [DEF_TIME_BITS-1:0] timestamp;
        logic [DEF_NBEAMS-1:0]    beams;
    } trig_record_t;

endpackage : l1_trigger_pkg
`default_nettype wire

// File: rtl/l1_trigger_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : trig_event_fifo
//  Purpose  : Synchronous event FIFO with a valid/ready read side, level
//             output and full/empty flags. Read data comes straight from
//             storage, so a record written this edge is visible next cycle.
//  Revision : 1.0  initial release
// ============================================================================
module trig_event_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_valid,
    input  logic [W-1:0]             i_wr_data,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [LW-1:0] r_wptr;
    logic [LW-1:0] r_rptr;
    logic [LW-1:0] w_level;
    logic          w_pop;
    logic          w_push;

    assign w_level    = r_wptr - r_rptr;
    assign o_level    = w_level;
    assign o_full     = (w_level == LW'(DEPTH));
    assign o_empty    = (w_level == '0);
    assign o_rd_valid = ~o_empty;
    assign o_rd_data  = r_mem[r_rptr[AW-1:0]];
    assign w_pop      = o_rd_valid & i_rd_ready;
    // A full FIFO still accepts a write when a read frees a slot this cycle.
    assign w_push     = i_wr_valid & (~o_full | w_pop);

    // Pointer update and storage write; reset also wipes stored records.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_wr_data;
                r_wptr                <= r_wptr + LW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LW'(1);
            end
        end
    end

endmodule : trig_event_fifo
`default_nettype wire

// File: rtl/l1_trigger_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : l1_trigger_arbiter
//  Purpose  : Per-beam holdoff/mask qualification of L1 triggers, timestamped
//             coalesced event records, FIFO buffering onto a valid/ready
//             stream, and a saturating dropped-record counter.
//             NBEAMS and TIME_BITS must match the package record type.
//  Revision : 1.0  initial release
// ============================================================================
module l1_trigger_arbiter
    import l1_trigger_pkg::*;
#(
    parameter int NBEAMS         = DEF_NBEAMS,
    parameter int HOLDOFF_CLOCKS = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIME_BITS      = DEF_TIME_BITS
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            enable_i,
    input  logic [NBEAMS-1:0]               trigger_i,
    input  logic [NBEAMS-1:0]               beam_mask_i,
    input  logic                            clear_overflow_i,
    output logic [TIME_BITS+NBEAMS-1:0]     trig_tdata_o,
    output logic                            trig_tvalid_o,
    input  logic                            trig_tready_i,
    output logic [OVF_BITS-1:0]             overflow_count_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

    localparam int HB = (HOLDOFF_CLOCKS < 1) ? 1 : $clog2(HOLDOFF_CLOCKS + 1);

    logic [TIME_BITS-1:0] r_ts;
    logic [NBEAMS-1:0]    w_qual;
    trig_record_t         r_rec;
    logic                 r_rec_vld;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_drop;
    logic [OVF_BITS-1:0]  r_ovf;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_ts <= '0;
        else          r_ts <= r_ts + TIME_BITS'(1);
    end

    generate
        for (genvar gi = 0; gi < NBEAMS; gi++) begin : g_beam
            logic [HB-1:0] r_holdoff;

            assign w_qual[gi] = enable_i & trigger_i[gi] & ~beam_mask_i[gi]
                              & (r_holdoff == '0);

            // Arm on qualify; otherwise count down regardless of enable/mask.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn)               r_holdoff <= '0;
                else if (w_qual[gi])        r_holdoff <= HB'(HOLDOFF_CLOCKS);
                else if (r_holdoff != '0)   r_holdoff <= r_holdoff - HB'(1);
            end
        end
    endgenerate

    // Capture one record per cycle in which any beam qualifies.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rec     <= '0;
            r_rec_vld <= 1'b0;
        end else begin
            r_rec_vld <= |w_qual;
            if (|w_qual) begin
                r_rec.timestamp <= r_ts;
                r_rec.beams     <= w_qual;
            end
        end
    end

    trig_event_fifo #(
        .W     (TIME_BITS + NBEAMS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (aclk),
        .rst_n      (aresetn),
        .i_wr_valid (r_rec_vld),
        .i_wr_data  (r_rec),
        .o_rd_data  (trig_tdata_o),
        .o_rd_valid (trig_tvalid_o),
        .i_rd_ready (trig_tready_i),
        .o_level    (fifo_level_o),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_pop  = ~w_empty & trig_tready_i;
    assign w_drop = r_rec_vld & w_full & ~w_pop;

    // Saturating drop counter; a clear in the same cycle as a drop wins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                   r_ovf <= '0;
        else if (clear_overflow_i)                      r_ovf <= '0;
        else if (w_drop && (r_ovf != {OVF_BITS{1'b1}})) r_ovf <= r_ovf + OVF_BITS'(1);
    end

    assign overflow_count_o = r_ovf;

endmodule : l1_trigger_arbiter
`default_nettype wire

// File: tb/tb_l1_trigger_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l1_trigger_arbiter
//  Purpose  : Directed self-checking bench for l1_trigger_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l1_trigger_arbiter;

    localparam int NB = 2;
    localparam int TW = 32;
    localparam int DW = TW + NB;

    logic          aclk;
    logic          aresetn;
    logic          enable_i;
    logic [NB-1:0] trigger_i;
    logic [NB-1:0] beam_mask_i;
    logic          clear_overflow_i;
    logic [DW-1:0] trig_tdata_o;
    logic          trig_tvalid_o;
    logic          trig_tready_i;
    logic [15:0]   overflow_count_o;
    logic [2:0]    fifo_level_o;

    int errors = 0;
    int checks = 0;

    // Bench's own view of the timestamp in the current cycle.
    logic [31:0]   tb_ts;
    logic [DW-1:0] q_data [$];
    logic [31:0]   q_time [$];

    l1_trigger_arbiter #(
        .NBEAMS(NB), .HOLDOFF_CLOCKS(16), .FIFO_DEPTH(4), .TIME_BITS(TW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .enable_i         (enable_i),
        .trigger_i        (trigger_i),
        .beam_mask_i      (beam_mask_i),
        .clear_overflow_i (clear_overflow_i),
        .trig_tdata_o     (trig_tdata_o),
        .trig_tvalid_o    (trig_tvalid_o),
        .trig_tready_i    (trig_tready_i),
        .overflow_count_o (overflow_count_o),
        .fifo_level_o     (fifo_level_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) tb_ts <= 32'd0;
        else          tb_ts <= tb_ts + 32'd1;
    end

    // Log every transfer with the cycle it happened in.
    always @(negedge aclk) begin
        if (aresetn && trig_tvalid_o && trig_tready_i) begin
            q_data.push_back(trig_tdata_o);
            q_time.push_back(tb_ts);
        end
    end

    // Advance to just after the edge that starts cycle T.
    task automatic tick_to(input int t);
        @(posedge aclk); #1;
        while (tb_ts < 32'(t)) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic pulse(input int t, input logic [NB-1:0] b);
        tick_to(t);     trigger_i = b;
        tick_to(t + 1); trigger_i = '0;
    endtask

    task automatic test_reset;
        aresetn = 1'b0; enable_i = 1'b1; trigger_i = '0; beam_mask_i = '0;
        clear_overflow_i = 1'b0; trig_tready_i = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (trig_tvalid_o !== 1'b0 || trig_tdata_o !== '0 || fifo_level_o !== 3'd0
            || overflow_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h level=%0d ovf=%0d, want all 0",
                     trig_tvalid_o, trig_tdata_o, fifo_level_o, overflow_count_o);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_holdoff;
        int exp_t [3] = '{10, 27, 44};
        q_data.delete(); q_time.delete();
        tick_to(10); trigger_i = 2'b01;
        tick_to(51); trigger_i = 2'b00;
        tick_to(70);
        checks++;
        if (q_data.size() != 3) begin
            errors++;
            $display("FAIL holdoff_count: got %0d records, want 3", q_data.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_data.size() <= i) begin
                errors++;
                $display("FAIL holdoff_rec%0d: missing, want ts=%0d", i, exp_t[i]);
            end else if (q_data[i] !== {32'(exp_t[i]), 2'b01} || q_time[i] !== 32'(exp_t[i] + 2)) begin
                errors++;
                $display("FAIL holdoff_rec%0d: got data=%h at %0d, want %h at %0d", i,
                         q_data[i], q_time[i], {32'(exp_t[i]), 2'b01}, exp_t[i] + 2);
            end
        end
    endtask

    task automatic test_single_pulse;
        pulse(100, 2'b01);
        @(negedge aclk);
        checks++;
        if (trig_tvalid_o !== 1'b0) begin
            errors++; $display("FAIL single_ts101: valid=%b, want 0", trig_tvalid_o);
        end
        @(negedge aclk);
        checks++;
        if (trig_tvalid_o !== 1'b1 || trig_tdata_o !== {32'd100, 2'b01}) begin
            errors++;
            $display("FAIL single_ts102: valid=%b data=%h, want 1 %h",
                     trig_tvalid_o, trig_tdata_o, {32'd100, 2'b01});
        end
        @(negedge aclk);
        checks++;
        if (trig_tvalid_o !== 1'b0) begin
            errors++; $display("FAIL single_ts103: valid=%b, want 0", trig_tvalid_o);
        end
    endtask

    task automatic test_coalesce_mask;
        q_data.delete(); q_time.delete();
        pulse(200, 2'b11);
        tick_to(215);
        checks++;
        if (q_data.size() != 1 || q_data[0] !== {32'd200, 2'b11}) begin
            errors++;
            $display("FAIL coalesce: got %0d records first=%h, want 1 %h",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : '0, {32'd200, 2'b11});
        end
        q_data.delete(); q_time.delete();
        beam_mask_i = 2'b10;
        pulse(300, 2'b11);
        tick_to(315);
        checks++;
        if (q_data.size() != 1 || q_data[0] !== {32'd300, 2'b01}) begin
            errors++;
            $display("FAIL mask: got %0d records first=%h, want 1 %h",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : '0, {32'd300, 2'b01});
        end
        q_data.delete(); q_time.delete();
        beam_mask_i = 2'b00; enable_i = 1'b0;
        pulse(400, 2'b11);
        tick_to(420);
        checks++;
        if (q_data.size() != 0) begin
            errors++; $display("FAIL disabled: got %0d records, want 0", q_data.size());
        end
        enable_i = 1'b1;
    endtask

    task automatic test_overflow;
        q_data.delete(); q_time.delete();
        tick_to(495); trig_tready_i = 1'b0;
        for (int i = 0; i < 6; i++) pulse(500 + 20 * i, 2'b01);
        tick_to(610);
        @(negedge aclk);
        checks++;
        if (fifo_level_o !== 3'd4 || overflow_count_o !== 16'd2 || trig_tvalid_o !== 1'b1
            || trig_tdata_o !== {32'd500, 2'b01}) begin
            errors++;
            $display("FAIL ovf_full: level=%0d ovf=%0d valid=%b data=%h, want 4 2 1 %h",
                     fifo_level_o, overflow_count_o, trig_tvalid_o, trig_tdata_o, {32'd500, 2'b01});
        end
        tick_to(620); trig_tready_i = 1'b1;
        tick_to(625);
        @(negedge aclk);
        checks++;
        if (q_data.size() != 4 || trig_tvalid_o !== 1'b0 || fifo_level_o !== 3'd0) begin
            errors++;
            $display("FAIL ovf_drain: got %0d xfers valid=%b level=%0d, want 4 0 0",
                     q_data.size(), trig_tvalid_o, fifo_level_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_data.size() <= i) begin
                errors++; $display("FAIL ovf_rec%0d: missing", i);
            end else if (q_data[i] !== {32'(500 + 20 * i), 2'b01} || q_time[i] !== 32'(620 + i)) begin
                errors++;
                $display("FAIL ovf_rec%0d: got %h at %0d, want %h at %0d", i, q_data[i], q_time[i],
                         {32'(500 + 20 * i), 2'b01}, 620 + i);
            end
        end
        tick_to(630); clear_overflow_i = 1'b1;
        @(negedge aclk);
        checks++;
        if (overflow_count_o !== 16'd2) begin
            errors++; $display("FAIL ovf_preclear: got %0d, want 2", overflow_count_o);
        end
        tick_to(631); clear_overflow_i = 1'b0;
        @(negedge aclk);
        checks++;
        if (overflow_count_o !== 16'd0) begin
            errors++; $display("FAIL ovf_clear: got %0d, want 0", overflow_count_o);
        end
    endtask

    task automatic test_clear_wins;
        tick_to(695); trig_tready_i = 1'b0;
        for (int i = 0; i < 5; i++) pulse(700 + 20 * i, 2'b01);
        // Pulse at 780 tries to push during cycle 781: clear it there.
        tick_to(781); clear_overflow_i = 1'b1;
        tick_to(782); clear_overflow_i = 1'b0;
        @(negedge aclk);
        checks++;
        if (overflow_count_o !== 16'd0 || fifo_level_o !== 3'd4) begin
            errors++;
            $display("FAIL clear_wins: ovf=%0d level=%0d, want 0 4", overflow_count_o, fifo_level_o);
        end
        pulse(800, 2'b01);
        tick_to(802);
        @(negedge aclk);
        checks++;
        if (overflow_count_o !== 16'd1) begin
            errors++; $display("FAIL drop_count: got %0d, want 1", overflow_count_o);
        end
        tick_to(810); trig_tready_i = 1'b1;
        tick_to(820); trig_tready_i = 1'b0;
    endtask

    task automatic test_back_to_back_backpressure;
        logic          p_valid;
        logic          p_ready;
        logic [DW-1:0] p_data;
        int            exp_t [3] = '{830, 850, 870};
        q_data.delete(); q_time.delete();
        for (int i = 0; i < 3; i++) pulse(830 + 20 * i, 2'b10);
        tick_to(879);
        p_valid = 1'b0; p_ready = 1'b1; p_data = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge aclk); #1;
            trig_tready_i = k[0];
            @(negedge aclk);
            if (p_valid && !p_ready) begin
                checks++;
                if (trig_tvalid_o !== 1'b1 || trig_tdata_o !== p_data) begin
                    errors++;
                    $display("FAIL bp_stable: valid=%b data=%h, want 1 %h",
                             trig_tvalid_o, trig_tdata_o, p_data);
                end
            end
            p_valid = trig_tvalid_o; p_ready = trig_tready_i; p_data = trig_tdata_o;
        end
        checks++;
        if (q_data.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d xfers, want 3", q_data.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== {32'(exp_t[i]), 2'b10}) begin
                errors++;
                $display("FAIL bp_rec%0d: got %h, want %h", i,
                         (q_data.size() > i) ? q_data[i] : '0, {32'(exp_t[i]), 2'b10});
            end
        end
        trig_tready_i = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) pulse(920 + 20 * i, 2'b01);
        tick_to(970);
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (trig_tvalid_o !== 1'b0 || fifo_level_o !== 3'd0 || trig_tdata_o !== '0
            || overflow_count_o !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b level=%0d data=%h ovf=%0d, want all 0",
                     trig_tvalid_o, fifo_level_o, trig_tdata_o, overflow_count_o);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1; trig_tready_i = 1'b1;
        q_data.delete(); q_time.delete();
        pulse(5, 2'b01);
        tick_to(12);
        checks++;
        if (q_data.size() != 1 || q_data[0] !== {32'd5, 2'b01} || q_time[0] !== 32'd7) begin
            errors++;
            $display("FAIL post_reset: got %0d recs first=%h at %0d, want 1 %h at 7",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : '0,
                     (q_time.size() > 0) ? q_time[0] : 32'd0, {32'd5, 2'b01});
        end
    endtask

    initial begin
        test_reset();
        test_holdoff();
        test_single_pulse();
        test_coalesce_mask();
        test_overflow();
        test_clear_wins();
        test_back_to_back_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule : tb_l1_trigger_arbiter
`default_nettype wire
